// File: rtl/wedge_pkg.sv
// Shared types and width helpers for the wedge transmitter.
package wedge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } wedge_state_e;

    // Bits needed to hold the values 0..max_val (never less than one bit).
    function automatic int wedge_cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int wedge_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/wedge_tx_pending.sv
// Saturating up/down counter of queued pulse requests with drop detection.
module wedge_tx_pending
    import wedge_pkg::*;
#(
    parameter  int MAX_PENDING = 7,
    localparam int CNT_W       = wedge_cnt_w(MAX_PENDING)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             overflow_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // Next count: increment and decrement together cancel, so a full queue
    // only drops a request when nothing is taken in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (en_i) begin
            if (inc_i && !dec_i) begin
                if (cnt_q == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else if (!inc_i && dec_i) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    // Count and overflow pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/wedge_tx.sv
// Pulse-to-level transmitter: each request becomes a high phase of fixed
// length followed by a low phase of minimum length, so a synchronizing edge
// detector in a slower domain sees every edge. Requests arriving while a
// pulse is in flight are queued.
module wedge_tx
    import wedge_pkg::*;
#(
    parameter  int HIGH_CYCLES = 3,
    parameter  int LOW_CYCLES  = 3,
    parameter  int MAX_PENDING = 7,
    localparam int CNT_W       = wedge_cnt_w(MAX_PENDING)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             req_i,
    output logic             serial_o,
    output logic             r_edge_o,
    output logic             f_edge_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] pending_o,
    output logic             overflow_o
);

    localparam int PH_W = wedge_cnt_w(wedge_max(HIGH_CYCLES, LOW_CYCLES));
    localparam logic [PH_W-1:0] PH_HIGH = PH_W'(HIGH_CYCLES);
    localparam logic [PH_W-1:0] PH_LOW  = PH_W'(LOW_CYCLES);
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

    if (HIGH_CYCLES < 1) begin : g_bad_high
        $error("wedge_tx: HIGH_CYCLES must be >= 1");
    end
    if (LOW_CYCLES < 1) begin : g_bad_low
        $error("wedge_tx: LOW_CYCLES must be >= 1");
    end
    if (MAX_PENDING < 1) begin : g_bad_pend
        $error("wedge_tx: MAX_PENDING must be >= 1");
    end

    wedge_state_e     state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             serial_q, serial_d;
    logic             r_edge_q, r_edge_d;
    logic             f_edge_q, f_edge_d;
    logic             launch;
    logic             pend_nz;
    logic             req_v;
    logic             take;
    logic             inc;
    logic [CNT_W-1:0] pend_cnt;

    assign req_v   = req_i & en_i;
    assign pend_nz = (pend_cnt != '0);

    // Next-state logic: a launch starts a high phase from IDLE or from the
    // end of a low phase; clear overrides everything.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        serial_d = serial_q;
        r_edge_d = 1'b0;
        f_edge_d = 1'b0;
        launch   = 1'b0;
        if (en_i) begin
            case (state_q)
                IDLE: begin
                    launch = req_v | pend_nz;
                end
                HIGH: begin
                    if (phase_q == PH_HIGH) begin
                        state_d  = LOW;
                        phase_d  = PH_ONE;
                        serial_d = 1'b0;
                        f_edge_d = 1'b1;
                    end else begin
                        phase_d = phase_q + PH_ONE;
                    end
                end
                LOW: begin
                    if (phase_q == PH_LOW) begin
                        if (req_v || pend_nz) begin
                            launch = 1'b1;
                        end else begin
                            state_d = IDLE;
                            phase_d = '0;
                        end
                    end else begin
                        phase_d = phase_q + PH_ONE;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    phase_d  = '0;
                    serial_d = 1'b0;
                end
            endcase
            if (launch) begin
                state_d  = HIGH;
                phase_d  = PH_ONE;
                serial_d = 1'b1;
                r_edge_d = 1'b1;
            end
        end
        if (clr_i) begin
            state_d  = IDLE;
            phase_d  = '0;
            serial_d = 1'b0;
            r_edge_d = 1'b0;
            f_edge_d = 1'b0;
            launch   = 1'b0;
        end
    end

    // A launch with an empty queue consumes the current request directly;
    // otherwise it takes a queued one and the current request is queued.
    assign take = launch & pend_nz;
    assign inc  = req_i & ~(launch & ~pend_nz);

    // FSM, phase counter, output level and edge-flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            serial_q <= 1'b0;
            r_edge_q <= 1'b0;
            f_edge_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            serial_q <= serial_d;
            r_edge_q <= r_edge_d;
            f_edge_q <= f_edge_d;
        end
    end

    wedge_tx_pending #(
        .MAX_PENDING(MAX_PENDING)
    ) u_pending (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (clr_i),
        .en_i      (en_i),
        .inc_i     (inc),
        .dec_i     (take),
        .cnt_o     (pend_cnt),
        .overflow_o(overflow_o)
    );

    assign serial_o  = serial_q;
    assign r_edge_o  = r_edge_q;
    assign f_edge_o  = f_edge_q;
    assign pending_o = pend_cnt;
    assign busy_o    = (state_q != IDLE) | pend_nz;

endmodule

// File: tb/tb_wedge_tx.sv
// Directed bench for wedge_tx: default instance, a MAX_PENDING=2 instance
// and a 6/6 instance looped back into a half-rate synchronizing receiver.
// Cycle n is the period after the n-th rising edge of a test; inputs are
// driven just after the edge and outputs are sampled on the falling edge.
module tb_wedge_tx;

    logic clk, rclk, rst_n;

    // Default instance.
    logic       req_a, en_a, clr_a;
    logic       ser_a, re_a, fe_a, busy_a, ovf_a;
    logic [2:0] pend_a;

    // MAX_PENDING = 2 instance.
    logic       req_b, en_b, clr_b;
    logic       ser_b, re_b, fe_b, busy_b, ovf_b;
    logic [1:0] pend_b;

    // Loopback instance, HIGH = LOW = 6.
    logic       req_c, en_c, clr_c;
    logic       ser_c, re_c, fe_c, busy_c, ovf_c;
    logic [4:0] pend_c;

    int n_cmp = 0;
    int n_err = 0;

    wedge_tx u_dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr_a), .en_i(en_a), .req_i(req_a),
        .serial_o(ser_a), .r_edge_o(re_a), .f_edge_o(fe_a), .busy_o(busy_a),
        .pending_o(pend_a), .overflow_o(ovf_a)
    );

    wedge_tx #(.MAX_PENDING(2)) u_ovf (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr_b), .en_i(en_b), .req_i(req_b),
        .serial_o(ser_b), .r_edge_o(re_b), .f_edge_o(fe_b), .busy_o(busy_b),
        .pending_o(pend_b), .overflow_o(ovf_b)
    );

    wedge_tx #(.HIGH_CYCLES(6), .LOW_CYCLES(6), .MAX_PENDING(31)) u_lb (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr_c), .en_i(en_c), .req_i(req_c),
        .serial_o(ser_c), .r_edge_o(re_c), .f_edge_o(fe_c), .busy_o(busy_c),
        .pending_o(pend_c), .overflow_o(ovf_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rclk = 1'b0;
        forever #10 rclk = ~rclk;
    end

    // Two-stage synchronizer plus edge detector in the half-rate domain.
    logic s1, s2, s3;
    int   rx_rise, rx_fall;
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
            rx_rise <= 0; rx_fall <= 0;
        end else begin
            s1 <= ser_c; s2 <= s1; s3 <= s2;
            if (s2 && !s3) rx_rise <= rx_rise + 1;
            if (!s2 && s3) rx_fall <= rx_fall + 1;
        end
    end

    int lb_ovf_cnt = 0;
    always_ff @(posedge clk) begin
        if (ovf_c) lb_ovf_cnt <= lb_ovf_cnt + 1;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pmax;
        int npulse;
        rst_n = 1'b0;
        req_a = 1'b0; en_a = 1'b1; clr_a = 1'b0;
        req_b = 1'b0; en_b = 1'b1; clr_b = 1'b0;
        req_c = 1'b0; en_c = 1'b1; clr_c = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.ser",  ser_a,  0);
        chk("rst.busy", busy_a, 0);
        chk("rst.pend", pend_a, 0);
        chk("rst.re",   re_a,   0);
        chk("rst.fe",   fe_a,   0);
        chk("rst.ovf",  ovf_a,  0);
        rst_n = 1'b1;
        tick();
        tick();

        // Single pulse: high cycles 1-3, low 4-6, idle from 7.
        for (int c = 0; c < 9; c++) begin
            req_a = (c == 0);
            @(negedge clk);
            chk($sformatf("pulse.ser@%0d", c),  ser_a,  int'(c >= 1 && c <= 3));
            chk($sformatf("pulse.re@%0d", c),   re_a,   int'(c == 1));
            chk($sformatf("pulse.fe@%0d", c),   fe_a,   int'(c == 4));
            chk($sformatf("pulse.busy@%0d", c), busy_a, int'(c >= 1 && c <= 6));
            chk($sformatf("pulse.pend@%0d", c), pend_a, 0);
            tick();
        end
        req_a = 1'b0;

        // Burst of four requests: rising edges 1, 7, 13, 19; idle at 25.
        pmax = 0;
        for (int c = 0; c < 27; c++) begin
            req_a = (c <= 3);
            @(negedge clk);
            if (int'(pend_a) > pmax) pmax = int'(pend_a);
            chk($sformatf("burst.re@%0d", c), re_a,
                int'(c == 1 || c == 7 || c == 13 || c == 19));
            chk($sformatf("burst.ser@%0d", c), ser_a,
                int'((c >= 1 && c <= 3) || (c >= 7 && c <= 9) ||
                     (c >= 13 && c <= 15) || (c >= 19 && c <= 21)));
            chk($sformatf("burst.busy@%0d", c), busy_a, int'(c >= 1 && c <= 24));
            if (c == 4)  chk("burst.pend@4",  pend_a, 3);
            if (c == 7)  chk("burst.pend@7",  pend_a, 2);
            if (c == 13) chk("burst.pend@13", pend_a, 1);
            if (c == 19) chk("burst.pend@19", pend_a, 0);
            tick();
        end
        req_a = 1'b0;
        chk("burst.pend_peak", pmax, 3);

        // Overflow, MAX_PENDING=2: requests of cycles 3 and 4 are dropped and
        // flagged in the cycle after each; three pulses in total.
        npulse = 0;
        for (int c = 0; c < 41; c++) begin
            req_b = (c <= 4);
            @(negedge clk);
            if (re_b) npulse++;
            chk($sformatf("ovf.flag@%0d", c), ovf_b, int'(c == 4 || c == 5));
            if (c == 3)  chk("ovf.pend@3",  pend_b, 2);
            if (c == 5)  chk("ovf.pend@5",  pend_b, 2);
            if (c == 7)  chk("ovf.pend@7",  pend_b, 1);
            if (c == 13) chk("ovf.pend@13", pend_b, 0);
            tick();
        end
        req_b = 1'b0;
        chk("ovf.pulses", npulse, 3);

        // Enable freeze: en low in cycles 3-5, high phase counts cycles 1, 2, 6.
        for (int c = 0; c < 12; c++) begin
            req_a = (c == 0 || c == 4);
            en_a  = !(c >= 3 && c <= 5);
            @(negedge clk);
            chk($sformatf("en.ser@%0d", c),  ser_a,  int'(c >= 1 && c <= 6));
            chk($sformatf("en.fe@%0d", c),   fe_a,   int'(c == 7));
            chk($sformatf("en.pend@%0d", c), pend_a, 0);
            chk($sformatf("en.ovf@%0d", c),  ovf_a,  0);
            chk($sformatf("en.busy@%0d", c), busy_a, int'(c >= 1 && c <= 9));
            tick();
        end
        req_a = 1'b0;
        en_a  = 1'b1;

        // Synchronous clear at the last high cycle with two queued requests.
        for (int c = 0; c < 7; c++) begin
            req_a = (c <= 2);
            clr_a = (c == 3);
            @(negedge clk);
            if (c == 3) begin
                chk("clr.pend@3", pend_a, 2);
                chk("clr.ser@3",  ser_a,  1);
            end
            if (c >= 4) begin
                chk($sformatf("clr.ser@%0d", c),  ser_a,  0);
                chk($sformatf("clr.pend@%0d", c), pend_a, 0);
                chk($sformatf("clr.busy@%0d", c), busy_a, 0);
                chk($sformatf("clr.fe@%0d", c),   fe_a,   0);
                chk($sformatf("clr.re@%0d", c),   re_a,   0);
            end
            tick();
        end
        clr_a = 1'b0;

        // Asynchronous reset in the middle of a high phase with one queued.
        for (int c = 0; c < 3; c++) begin
            req_a = (c <= 1);
            @(negedge clk);
            if (c == 2) begin
                chk("arst.pend_before", pend_a, 1);
                chk("arst.ser_before",  ser_a,  1);
            end
            tick();
        end
        req_a = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.ser",  ser_a,  0);
        chk("arst.pend", pend_a, 0);
        chk("arst.busy", busy_a, 0);
        chk("arst.fe",   fe_a,   0);
        chk("arst.re",   re_a,   0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("arst.ser_after",  ser_a,  0);
        chk("arst.busy_after", busy_a, 0);
        tick();

        // Loopback: 20 requests with random gaps into the half-rate receiver.
        for (int i = 0; i < 20; i++) begin
            req_c = 1'b1;
            tick();
            req_c = 1'b0;
            repeat ($urandom_range(0, 15)) tick();
        end
        for (int k = 0; k < 3000 && busy_c; k++) tick();
        chk("lb.idle", busy_c, 0);
        repeat (8) @(posedge rclk);
        #1;
        chk("lb.rise", rx_rise, 20);
        chk("lb.fall", rx_fall, 20);
        chk("lb.ovf",  lb_ovf_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
